// File: rtl/cm0_mtx_in_stage.sv
// Bus-matrix input stage: holds an address phase the output stage
// cannot take yet and stalls the master until it is issued.
module cm0_mtx_in_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              HSELI,
  output logic [ADDR_W-1:0] HADDRI,
  output logic [1:0]        HTRANSI,
  output logic              HWRITEI,
  output logic [2:0]        HSIZEI,
  output logic [2:0]        HBURSTI,
  output logic [3:0]        HPROTI,
  output logic              HMASTLOCKI,
  output logic              req_port,
  input  logic              addr_active,
  input  logic              data_active,
  input  logic              HREADYM,
  input  logic              HRESPM
);

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } addr_ph_t;

  logic     valid_tran;
  logic     issue;
  logic     capture;
  logic     held_tran;
  logic     held_nxt;
  addr_ph_t live_ph;
  addr_ph_t hold_ph;
  addr_ph_t out_ph;

  assign valid_tran = HSELS & HREADYS & HTRANSS[1];
  assign issue      = addr_active & HREADYM;
  assign capture    = valid_tran & ~issue;

  assign live_ph = '{
    sel:   HSELS & HREADYS,
    addr:  HADDRS,
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  always_comb begin
    held_nxt = held_tran;
    unique case (1'b1)
      capture:           held_nxt = 1'b1;
      held_tran & issue: held_nxt = 1'b0;
      default:           held_nxt = held_tran;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_tran <= 1'b0;
    end else begin
      held_tran <= held_nxt;
    end
  end

  // Only a transfer that is actually being stalled is captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_ph <= '0;
    end else if (capture) begin
      hold_ph <= live_ph;
    end
  end

  assign out_ph = held_tran ? hold_ph : live_ph;

  assign HSELI      = out_ph.sel;
  assign HADDRI     = out_ph.addr;
  assign HTRANSI    = out_ph.trans;
  assign HWRITEI    = out_ph.write;
  assign HSIZEI     = out_ph.size;
  assign HBURSTI    = out_ph.burst;
  assign HPROTI     = out_ph.prot;
  assign HMASTLOCKI = out_ph.lock;

  assign req_port = held_tran | valid_tran;

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    unique case (1'b1)
      held_tran: begin
        HREADYOUTS = 1'b0;
        HRESPS     = 1'b0;
      end
      data_active: begin
        HREADYOUTS = HREADYM;
        HRESPS     = HRESPM;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

endmodule
